// File: rtl/mem_wb_stage.sv
// MEM stage with a blocking single-outstanding memory handshake and the MEM/WB pipeline register.
// A memory op issues for one cycle, then waits for ack (or times out into a sticky error state).
module mem_wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_mem_to_reg,
    input  logic        in_reg_write,
    input  logic [15:0] in_alu_val,
    input  logic [15:0] in_store_data,
    input  logic [3:0]  in_dst_reg,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [3:0]  wb_dst_reg,
    output logic [15:0] wb_data,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [15:0] addr_q, wdata_q;
    logic        issue;

    // Gating with rst_n keeps the combinational request outputs quiet while reset is held.
    assign issue = rst_n && (state_q == IDLE) && in_valid && (in_mem_read || in_mem_write);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = WAIT;
                    cnt_d   = 5'd0;
                    stall   = 1'b1;
                end
            end
            WAIT: begin
                stall = ~mem_ack;
                if (mem_ack) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q + 5'd1 == TIMEOUT_CNT) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                stall = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Issued request is driven live in the issue cycle and held from the capture registers afterwards.
    assign mem_en    = issue;
    assign mem_wr    = issue ? in_mem_write  : wr_q;
    assign mem_addr  = issue ? in_alu_val    : addr_q;
    assign mem_wdata = issue ? in_store_data : wdata_q;
    assign err       = (state_q == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            wr_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) begin
                wr_q    <= in_mem_write;
                addr_q  <= in_alu_val;
                wdata_q <= in_store_data;
            end
        end
    end

    // MEM/WB register: a stalled edge inserts a bubble but keeps the last destination and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_dst_reg   <= 4'd0;
            wb_data      <= 16'd0;
        end else if (!stall) begin
            wb_valid     <= in_valid;
            wb_reg_write <= in_valid && in_reg_write && !in_mem_write;
            wb_dst_reg   <= in_dst_reg;
            wb_data      <= (in_mem_to_reg && in_mem_read) ? mem_rdata : in_alu_val;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage: an instruction-level reference model predicts the memory
// request, stall profile and MEM/WB results of each instruction from the block's stated rules.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write;
    logic [15:0] in_alu_val, in_store_data;
    logic [3:0]  in_dst_reg;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, stall;
    logic        wb_valid, wb_reg_write;
    logic [3:0]  wb_dst_reg;
    logic [15:0] wb_data;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int issue_cyc = 0;
    int first_issue = 0;
    logic [3:0]  exp_dst = 4'd0;
    logic [15:0] exp_data = 16'd0;

    mem_wb_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_alu_val(in_alu_val), .in_store_data(in_store_data), .in_dst_reg(in_dst_reg),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dst_reg(wb_dst_reg),
        .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_mem_to_reg = 1'b0; in_reg_write = 1'b0;
        in_alu_val = 16'd0; in_store_data = 16'd0; in_dst_reg = 4'd0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_rw"}, 32'(wb_reg_write), 32'd0);
        chk({tag, "_wb_dst"}, 32'(wb_dst_reg), 32'd0);
        chk({tag, "_wb_data"}, 32'(wb_data), 32'd0);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_bub_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_bub_rw"}, 32'(wb_reg_write), 32'd0);
        chk({tag, "_bub_dst"}, 32'(wb_dst_reg), 32'(exp_dst));
        chk({tag, "_bub_data"}, 32'(wb_data), 32'(exp_data));
    endtask

    // One instruction from the upstream register; memory ops are acked k cycles after issue.
    task automatic do_instr(input string tag, input logic v, input logic rd, input logic wr,
                            input logic m2r, input logic rw, input logic [15:0] alu,
                            input logic [15:0] sd, input logic [3:0] dst, input int k,
                            input logic [15:0] rdata);
        logic        is_mem;
        logic [15:0] rdata_at_edge;
        is_mem = v && (rd || wr);
        @(negedge clk);
        in_valid = v; in_mem_read = rd; in_mem_write = wr; in_mem_to_reg = m2r;
        in_reg_write = rw; in_alu_val = alu; in_store_data = sd; in_dst_reg = dst;
        mem_ack = 1'($urandom);
        mem_rdata = 16'($urandom);
        #1;
        chk({tag, "_issue_en"}, 32'(mem_en), 32'(is_mem));
        chk({tag, "_issue_stall"}, 32'(stall), 32'(is_mem));
        if (is_mem) begin
            issue_cyc = cyc;
            chk({tag, "_issue_wr"}, 32'(mem_wr), 32'(wr));
            chk({tag, "_issue_addr"}, 32'(mem_addr), 32'(alu));
            chk({tag, "_issue_wdata"}, 32'(mem_wdata), 32'(sd));
            for (int j = 1; j <= k; j++) begin
                @(posedge clk); #1;
                chk_bubble(tag);
                @(negedge clk);
                mem_ack = (j == k);
                mem_rdata = (j == k) ? rdata : 16'($urandom);
                #1;
                chk({tag, "_wait_en"}, 32'(mem_en), 32'd0);
                chk({tag, "_wait_stall"}, 32'(stall), 32'(j != k));
                chk({tag, "_wait_wr"}, 32'(mem_wr), 32'(wr));
                chk({tag, "_wait_addr"}, 32'(mem_addr), 32'(alu));
                chk({tag, "_wait_wdata"}, 32'(mem_wdata), 32'(sd));
                chk({tag, "_wait_err"}, 32'(err), 32'd0);
            end
        end
        rdata_at_edge = mem_rdata;
        @(posedge clk); #1;
        exp_dst  = dst;
        exp_data = (m2r && rd) ? rdata_at_edge : alu;
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'(v));
        chk({tag, "_wb_rw"}, 32'(wb_reg_write), 32'(v && rw && !wr));
        chk({tag, "_wb_dst"}, 32'(wb_dst_reg), 32'(exp_dst));
        chk({tag, "_wb_data"}, 32'(wb_data), 32'(exp_data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        zero_inputs();
        in_valid = 1'b1; in_mem_read = 1'b1; in_alu_val = 16'h5555; in_dst_reg = 4'd9;
        mem_ack = 1'b0; mem_rdata = 16'h0;
        #3;
        chk_all_zero("reset");
        #10;
        chk_all_zero("reset_clk");
        zero_inputs();
        #9 rst_n = 1'b1;

        // Directed scenarios
        do_instr("alu", 1, 0, 0, 0, 1, 16'h1234, 16'h0, 4'd3, 1, 16'h0);
        do_instr("load", 1, 1, 0, 1, 1, 16'h0040, 16'h7777, 4'd5, 3, 16'hBEEF);
        do_instr("store", 1, 0, 1, 0, 1, 16'h0010, 16'h00AA, 4'd7, 1, 16'h0);
        do_instr("rdwr", 1, 1, 1, 1, 1, 16'h0020, 16'h0BB0, 4'd2, 2, 16'hCAFE);
        do_instr("inval", 0, 1, 0, 1, 1, 16'h0099, 16'h0, 4'd4, 1, 16'h0);
        do_instr("b2b_a", 1, 1, 0, 1, 1, 16'h0100, 16'h0, 4'd1, 2, 16'h1111);
        first_issue = issue_cyc;
        do_instr("b2b_b", 1, 1, 0, 1, 1, 16'h0102, 16'h0, 4'd6, 2, 16'h2222);
        chk("b2b_gap", 32'(issue_cyc - first_issue), 32'd3);

        // Timeout into the sticky error state
        @(negedge clk);
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_mem_to_reg = 1'b1;
        in_reg_write = 1'b1; in_alu_val = 16'h0F00; in_dst_reg = 4'd8; mem_ack = 1'b0;
        #1 chk("to_issue_en", 32'(mem_en), 32'd1);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk); #1;
            chk("to_wait_err", 32'(err), 32'd0);
            chk("to_wait_stall", 32'(stall), 32'd1);
        end
        @(posedge clk); #1;
        chk("to_err", 32'(err), 32'd1);
        chk("to_stall", 32'(stall), 32'd1);
        chk("to_en", 32'(mem_en), 32'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'($urandom);
            #1 chk("err_ack_stall", 32'(stall), 32'd1);
            @(posedge clk); #1;
            chk("err_sticky", 32'(err), 32'd1);
            chk_bubble("err");
        end
        @(negedge clk);
        rst_n = 1'b0; mem_ack = 1'b0;
        #1 chk_all_zero("err_rst");
        zero_inputs();
        exp_dst = 4'd0; exp_data = 16'd0;
        #2 rst_n = 1'b1;
        do_instr("post_err", 1, 0, 0, 0, 1, 16'h4321, 16'h0, 4'd11, 1, 16'h0);

        // Reset asserted between edges while waiting for ack
        @(negedge clk);
        in_valid = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b1; in_reg_write = 1'b0;
        in_alu_val = 16'h0333; in_store_data = 16'h0444; in_dst_reg = 4'd12; mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 chk_all_zero("midwait_rst");
        @(negedge clk);
        zero_inputs();
        mem_ack = 1'b1;
        rst_n = 1'b1;
        exp_dst = 4'd0; exp_data = 16'd0;
        #1;
        chk("spur_ack_stall", 32'(stall), 32'd0);
        chk("spur_ack_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        chk("spur_ack_valid", 32'(wb_valid), 32'd0);
        chk("spur_ack_err", 32'(err), 32'd0);
        mem_ack = 1'b0;
        do_instr("post_mid", 1, 1, 0, 1, 1, 16'h0050, 16'h0, 4'd13, 2, 16'h5A5A);

        // Random instruction stream
        for (int i = 0; i < 120; i++) begin
            int          t;
            logic        v, rd, wr;
            t = int'($urandom_range(0, 4));
            v  = (t != 4);
            rd = (t == 1) || (t == 3) || ((t == 4) && 1'($urandom));
            wr = (t == 2) || (t == 3) || ((t == 4) && 1'($urandom));
            do_instr("rand", v, rd, wr, 1'($urandom), 1'($urandom), 16'($urandom),
                     16'($urandom), 4'($urandom), int'($urandom_range(1, 5)), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): TIMEOUT, 16, maximum cycles in WAIT before error.
REQ-002 The block SHALL have these ports (name, direction, width, meaning): clk, in, 1, single clock, all state on rising edge.
REQ-003 rst_n, in, 1, asynchronous active-low reset.
REQ-004 in_valid, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write, in, 1 each, control from the EX/MEM pipeline register.
REQ-005 in_alu_val, in, 16, ALU result or address; in_store_data, in, 16, store data; in_dst_reg, in, 4, destination register.
REQ-006 mem_en, out, 1, request pulse; mem_wr, out, 1, 1 = write; mem_addr, out, 16; mem_wdata, out, 16.
REQ-007 mem_rdata, in, 16, read data; mem_ack, in, 1, access complete, earliest one cycle after mem_en.
REQ-008 stall, out, 1, freeze upstream (drives EX/MEM write_en low).
REQ-009 wb_valid, wb_reg_write, out, 1 each; wb_dst_reg, out, 4; wb_data, out, 16 (MEM/WB register outputs).
REQ-010 err, out, 1, sticky memory-timeout flag.

Function
REQ-011 The FSM SHALL have states IDLE, WAIT and ERR.
REQ-012 In IDLE with in_valid & (in_mem_read | in_mem_write), the block SHALL assert mem_en=1 and stall=1 for that cycle, with mem_wr=in_mem_write, mem_addr=in_alu_val and mem_wdata=in_store_data, then enter WAIT.
REQ-013 If in_mem_read and in_mem_write are both 1, the access SHALL be treated as a write.
REQ-014 In WAIT, mem_en SHALL be 0, mem_addr, mem_wdata and mem_wr SHALL hold their issued values, and stall SHALL equal ~mem_ack.
REQ-015 In WAIT with mem_ack=1, the block SHALL return to IDLE at the next edge; stall is 0 in that cycle, so upstream advances.
REQ-016 mem_ack SHALL be ignored in IDLE and ERR.
REQ-017 A 5-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-018 If the counter reaches TIMEOUT without ack, the FSM SHALL enter ERR.
REQ-019 In ERR, stall SHALL be 1, err SHALL be 1 and mem_en SHALL be 0 until reset.
REQ-020 A non-memory instruction (in_valid with neither mem_read nor mem_write) SHALL cause no stall and SHALL pass to the MEM/WB register with 1-cycle latency.
REQ-021 The MEM/WB register SHALL update on each edge with stall=0: wb_valid<=in_valid, wb_reg_write<=in_valid & in_reg_write, wb_dst_reg<=in_dst_reg.
REQ-022 On that same edge, wb_data SHALL load mem_rdata when in_mem_to_reg & in_mem_read, and in_alu_val otherwise.
REQ-023 On each edge with stall=1, the MEM/WB register SHALL load a bubble: wb_valid=0 and wb_reg_write=0, with wb_dst_reg and wb_data held.
REQ-024 A store SHALL never set wb_reg_write, regardless of in_reg_write.
REQ-025 Memory-access latency SHALL be 1 issue cycle plus k wait cycles, where k is the cycle count up to and including the ack cycle; wb outputs SHALL update at the edge ending the ack cycle.
REQ-026 Back-to-back memory instructions SHALL each incur a separate issue cycle; no pipelining of requests.
REQ-027 in_valid=0 SHALL produce no memory request and a bubble in MEM/WB.

Reset
REQ-028 While rst_n=0, asynchronously: state=IDLE, counter=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, stall=0, err=0, wb_valid=0, wb_reg_write=0, wb_dst_reg=0, wb_data=0.
REQ-029 Reset asserted in WAIT or ERR SHALL abandon the access; the first edge after release SHALL evaluate inputs from IDLE.

Verification
REQ-030 ALU op in_alu_val=0x1234, dst=3, reg_write=1 -> next edge wb_valid=1, wb_reg_write=1, wb_dst_reg=3, wb_data=0x1234, stall never 1.
REQ-031 Load addr 0x0040, mem_to_reg=1, ack 3 cycles after mem_en with rdata=0xBEEF -> mem_en one pulse, mem_addr=0x0040 held, stall high 3 cycles, then wb_data=0xBEEF with wb_reg_write=1; bubbles appear in WB while stalled.
REQ-032 Store addr 0x0010, data 0x00AA, ack after 1 cycle -> mem_wr=1, mem_wdata=0x00AA, stall high 1 cycle, then wb_reg_write=0.
REQ-033 Load with no ack -> err=1 and stall=1 after TIMEOUT=16 WAIT cycles; later acks ignored; rst_n pulse -> err=0, state IDLE.
REQ-034 rst_n driven low mid-WAIT between clock edges -> all outputs 0 immediately; spurious ack after release -> ignored.
REQ-035 Two back-to-back loads, each acked after 2 cycles -> two mem_en pulses separated by 3 cycles; two correct wb_data values in order.
